ps2_kbd_decoder: RTL and testbench
==================================

# ps2_kbd_decoder

Downstream of the PS/2 receiver in the PS2 core of the MMIO subsystem: consumes each received byte (`rx_data` qualified by `rx_done_tick`) and turns Set-2 scan-code sequences into single key events. Resolves `E0` (extended), `F0` (break) and the 8-byte `E1` Pause sequence. Tracks modifier state (Shift, Ctrl, Alt, Caps Lock). Buffers events in a small first-word-fall-through FIFO that the MMIO wrapper pops.

## Interface
- `FIFO_AW`, default 2: FIFO address width; depth = 2^FIFO_AW (4 entries).
- `TIMEOUT_CYCLES`, default 2_000_000: idle cycles after which a partial sequence is abandoned (20 ms at 100 MHz).

Ports:
- `clk`  in  1  system clock; one clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  byte from the PS/2 receiver.
- `rx_done_tick`  in  1  one-cycle strobe, `rx_data` valid.
- `rd_en`  in  1  pop head event; ignored when empty.
- `ev_valid`  out  1  FIFO not empty.
- `ev_code`  out  8  head event scan code; 0 when empty.
- `ev_ext`  out  1  head event is extended (`E0`-prefixed); 0 when empty.
- `ev_brk`  out  1  head event is a release; 0 when empty.
- `fifo_full`  out  1  FIFO holds 2^FIFO_AW events.
- `ovf_tick`  out  1  one-cycle pulse, event dropped because FIFO full.
- `shift`, `ctrl`, `alt`  out  1 each  modifier currently held (left OR right).
- `caps_lock`  out  1  Caps Lock toggle state.

## Operation
- Parser FSM states: IDLE, EXT (after `E0`), BRK (after `F0`), EXT_BRK (after `E0 F0`), SKIP (inside Pause).
- Transitions, evaluated only on `rx_done_tick`:
  - IDLE: `E0`→EXT; `F0`→BRK; `E1`→SKIP with skip counter = 7.
  - IDLE: `00`, `AA`, `EE`, `FA`, `FE`, `FF` are discarded and the FSM stays in IDLE.
  - IDLE: any other byte emits {code, ext=0, brk=0}.
  - EXT: `F0`→EXT_BRK; any other byte emits {code, 1, 0}→IDLE.
  - BRK: emits {code, 0, 1}→IDLE.
  - EXT_BRK: emits {code, 1, 1}→IDLE.
  - SKIP: decrement counter on each byte; the byte that brings it to 0 emits {`E1`, 0, 0}→IDLE.
- Timeout: in any non-IDLE state a cycle counter runs. It clears on each `rx_done_tick`. Reaching TIMEOUT_CYCLES−1 forces IDLE with no event emitted.
- Modifiers update on every emitted event, independent of FIFO space. Registers: lshift, rshift, lctrl, rctrl, lalt, ralt, caps_held, caps_lock.
  - Non-extended `12` → lshift; `59` → rshift. Extended `12`/`59` (print-screen fake shift) has no effect.
  - `14` → lctrl, ext `14` → rctrl; `11` → lalt, ext `11` → ralt.
  - Make sets the flag; break clears it. `shift` = lshift|rshift, likewise `ctrl` and `alt`.
  - Caps: non-extended make `58` with caps_held=0 toggles caps_lock and sets caps_held. Make with caps_held=1 (typematic repeat) does nothing. Break `58` clears caps_held.
- FIFO: 10-bit entries {ext, brk, code}, first-word-fall-through, head drives `ev_*` combinationally and is masked to 0 when empty.
  - Push when an event is emitted.
  - Pop when `rd_en` && `ev_valid`.
  - Full with no pop in the same cycle: event dropped, `ovf_tick`=1 for one cycle.
  - Full with pop in the same cycle: both succeed, no overflow.
  - Empty with push and `rd_en` in the same cycle: push only (`ev_valid` was 0).
  - Pointers are FIFO_AW+1 bits wide and wrap naturally.

## Timing
- Reset values:
  - All `ev_*` = 0; `fifo_full` = 0; `ovf_tick` = 0.
  - All modifiers and `caps_lock` = 0.
  - FSM = IDLE; timeout counter and skip counter = 0.
- Reset mid-sequence (e.g. after `F0`) discards the prefix. The next byte is decoded from IDLE.
- Latency: final byte's `rx_done_tick` in cycle T → `ev_valid` and new modifier values visible in cycle T+1.
- `rd_en` in cycle T → next entry (or empty) visible in T+1.
- Back-to-back `rx_done_tick` on consecutive cycles must be accepted without loss.
- `ovf_tick` asserts in the cycle after the dropped event's final byte.

## Test plan
- Reset, then `1C` → cycle T+1: `ev_valid`=1, `ev_code`=1C, `ev_ext`=0, `ev_brk`=0. Pulse `rd_en` → `ev_valid`=0, `ev_code`=00.
- `E0 F0 75` → exactly one event {75, ext=1, brk=1}. `E1 14 77 E1 F0 14 F0 77` → exactly one event {E1, 0, 0}, and `ctrl` stays 0.
- `12`, `59`, `F0 12` → `shift`=1 throughout. `F0 59` → `shift`=0. `E0 12` → `shift` unchanged. `E0 14` → `ctrl`=1; `E0 F0 14` → `ctrl`=0.
- `58 58 58`, `F0 58`, `58` → `caps_lock` goes 0→1 on the first make, stays 1 through the repeats, →0 on the press after the release.
- Six make codes 01..06 with no reads → `fifo_full`=1 after the fourth, `ovf_tick` pulses on the fifth and sixth. Reads return 01..04 in order. Refill to full, then push with `rd_en` in the same cycle → no `ovf_tick`, count stays 4.
- `E0`, then TIMEOUT_CYCLES idle cycles, then `1C` → event {1C, ext=0}. `F0`, then `reset` for one cycle, then `1C` → event {1C, brk=0}.

Source files
------------

// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder
// Turns PS/2 Set-2 scan-code byte sequences into single key events
// {code, ext, brk}, tracks modifier state and buffers events in a small
// first-word-fall-through FIFO popped by the MMIO wrapper.
//
// Ports:
//   clk, reset          - system clock; synchronous active-high reset
//   rx_data/rx_done_tick - received byte and its one-cycle strobe
//   rd_en               - pop head event (ignored when empty)
//   ev_valid/ev_code/ev_ext/ev_brk - FIFO head, zeroed when empty
//   fifo_full, ovf_tick - FIFO full flag; pulse when an event is dropped
//   shift/ctrl/alt/caps_lock - modifier state
module ps2_kbd_decoder #(
  parameter int FIFO_AW        = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       rd_en,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       fifo_full,
  output logic       ovf_tick,
  output logic       shift,
  output logic       ctrl,
  output logic       alt,
  output logic       caps_lock
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t          state, state_n;
  logic [2:0]      skip_cnt, skip_n;
  logic [TW-1:0]   tmo_cnt;
  logic            emit, em_ext, em_brk;
  logic [7:0]      em_code;

  // ---------------- parser FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_n;
      skip_cnt <= skip_n;
    end
  end

  always_comb begin
    state_n = state;
    skip_n  = skip_cnt;
    emit    = 1'b0;
    em_code = rx_data;
    em_ext  = 1'b0;
    em_brk  = 1'b0;
    if (rx_done_tick) begin
      unique case (state)
        IDLE: begin
          unique case (rx_data)
            8'hE0: state_n = EXT;
            8'hF0: state_n = BRK;
            8'hE1: begin
              state_n = SKIP;
              skip_n  = 3'd7;
            end
            // keyboard status/ack bytes, never key codes
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
            default: emit = 1'b1;
          endcase
        end
        EXT: begin
          if (rx_data == 8'hF0) begin
            state_n = EXT_BRK;
          end else begin
            emit    = 1'b1;
            em_ext  = 1'b1;
            state_n = IDLE;
          end
        end
        BRK: begin
          emit    = 1'b1;
          em_brk  = 1'b1;
          state_n = IDLE;
        end
        EXT_BRK: begin
          emit    = 1'b1;
          em_ext  = 1'b1;
          em_brk  = 1'b1;
          state_n = IDLE;
        end
        SKIP: begin
          // Pause has no break code; the whole 8-byte burst becomes one make
          skip_n = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) begin
            emit    = 1'b1;
            em_code = 8'hE1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      // stale partial sequence (e.g. lost byte): abandon silently
      state_n = IDLE;
      skip_n  = '0;
    end
  end

  // idle-cycle counter only runs while a sequence is in progress
  always_ff @(posedge clk) begin
    if (reset || rx_done_tick || state_n == IDLE) tmo_cnt <= '0;
    else                                          tmo_cnt <= tmo_cnt + TW'(1);
  end

  // ---------------- modifiers ----------------
  logic lshift, rshift, lctrl, rctrl, lalt, ralt, caps_held;

  always_ff @(posedge clk) begin
    if (reset) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      lalt      <= 1'b0;
      ralt      <= 1'b0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
    end else if (emit) begin
      // extended 12/59 are the fake shifts around Print Screen: ignored
      unique case ({em_ext, em_code})
        9'h012: lshift <= ~em_brk;
        9'h059: rshift <= ~em_brk;
        9'h014: lctrl  <= ~em_brk;
        9'h114: rctrl  <= ~em_brk;
        9'h011: lalt   <= ~em_brk;
        9'h111: ralt   <= ~em_brk;
        9'h058: begin
          if (em_brk) begin
            caps_held <= 1'b0;
          end else if (!caps_held) begin
            // only the first make toggles; typematic repeats are ignored
            caps_lock <= ~caps_lock;
            caps_held <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign shift = lshift | rshift;
  assign ctrl  = lctrl  | rctrl;
  assign alt   = lalt   | ralt;

  // ---------------- event FIFO ----------------
  logic [9:0]       mem [DEPTH];
  logic [FIFO_AW:0] wptr, rptr, count;
  logic             empty, pop, push;
  logic [9:0]       head;

  assign count     = wptr - rptr;
  assign empty     = (wptr == rptr);
  assign fifo_full = (count == (FIFO_AW + 1)'(DEPTH));
  assign pop       = rd_en && !empty;
  // a pop in the same cycle frees the slot the push needs
  assign push      = emit && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      ovf_tick <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      ovf_tick <= emit && !push;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[FIFO_AW-1:0]] <= {em_ext, em_brk, em_code};
  end

  assign head     = mem[rptr[FIFO_AW-1:0]];
  assign ev_valid = !empty;
  assign ev_code  = empty ? 8'h00 : head[7:0];
  assign ev_ext   = !empty && head[9];
  assign ev_brk   = !empty && head[8];

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
module tb_ps2_kbd_decoder;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       rd_en;
  logic       ev_valid, ev_ext, ev_brk, fifo_full, ovf_tick;
  logic [7:0] ev_code;
  logic       shift, ctrl, alt, caps_lock;

  ps2_kbd_decoder #(.FIFO_AW(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .rd_en(rd_en), .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_brk(ev_brk), .fifo_full(fifo_full), .ovf_tick(ovf_tick),
    .shift(shift), .ctrl(ctrl), .alt(alt), .caps_lock(caps_lock)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // One byte, then expected head and modifiers, then optional pop.
  typedef struct {
    logic [7:0] b;
    logic       v;
    logic [7:0] code;
    logic       ext, brk, sh, ct, al, cp;
    logic       pop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] b, logic v, logic [7:0] code,
                              logic ext, logic brk, logic sh, logic ct,
                              logic al, logic cp);
    vec_t r;
    r.b = b; r.v = v; r.code = code; r.ext = ext; r.brk = brk;
    r.sh = sh; r.ct = ct; r.al = al; r.cp = cp; r.pop = v;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bytes are driven and outputs sampled on falling edges.
  task automatic send_byte(logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // check head then pop it
  task automatic expect_pop(string name, logic [7:0] code, logic ext, logic brk);
    chk(name, {21'd0, ev_valid, ev_ext, ev_brk, ev_code}, {21'd0, 1'b1, ext, brk, code});
    pop_one();
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_done_tick = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {18'd0, ev_valid, ev_code, ev_ext, ev_brk, fifo_full, ovf_tick, shift, ctrl, alt, caps_lock},
        32'd0);
    reset = 1'b0;

    //        byte   v  code  ext brk sh ct al cp
    tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h75, 1, 8'h75, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(8'h12, 1, 8'h12, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(8'h59, 1, 8'h59, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(8'h12, 1, 8'h12, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(8'h59, 1, 8'h59, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h12, 1, 8'h12, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h14, 1, 8'h14, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(8'h14, 1, 8'h14, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(8'h11, 1, 8'h11, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(8'h11, 1, 8'h11, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(8'h58, 1, 8'h58, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h58, 1, 8'h58, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h58, 1, 8'h58, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h58, 1, 8'h58, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(8'h58, 1, 8'h58, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hAA, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hFA, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    // Pause: E1 14 77 E1 F0 14 F0 77 -> one {E1,0,0}, ctrl untouched
    tbl.push_back(mk(8'hE1, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h14, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h77, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hE1, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h14, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h77, 1, 8'hE1, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      send_byte(tbl[i].b);
      chk($sformatf("vec%0d_byte%h", i, tbl[i].b),
          {17'd0, ev_valid, ev_code, ev_ext, ev_brk, shift, ctrl, alt, caps_lock},
          {17'd0, tbl[i].v, tbl[i].code, tbl[i].ext, tbl[i].brk,
           tbl[i].sh, tbl[i].ct, tbl[i].al, tbl[i].cp});
      if (tbl[i].pop) begin
        pop_one();
        chk($sformatf("vec%0d_popped", i), {23'd0, ev_valid, ev_code}, 32'd0);
      end
    end

    // ---- FIFO fill / overflow ----
    for (int k = 1; k <= 6; k++) begin
      send_byte(8'(k));
      chk($sformatf("fill%0d_full", k), {31'd0, fifo_full}, {31'd0, k >= 4});
      chk($sformatf("fill%0d_ovf", k), {31'd0, ovf_tick}, {31'd0, k >= 5});
    end
    @(negedge clk);
    chk("ovf_one_cycle", {31'd0, ovf_tick}, 32'd0);
    for (int k = 1; k <= 4; k++) expect_pop($sformatf("drain%0d", k), 8'(k), 1'b0, 1'b0);
    chk("drained_empty", {31'd0, ev_valid}, 32'd0);

    // full + simultaneous pop and push: no overflow, stays full
    for (int k = 7; k <= 10; k++) send_byte(8'(k));
    @(negedge clk);
    rx_data = 8'h0B; rx_done_tick = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; rd_en = 1'b0;
    chk("full_pushpop_ovf", {31'd0, ovf_tick}, 32'd0);
    chk("full_pushpop_full", {31'd0, fifo_full}, 32'd1);
    for (int k = 8; k <= 11; k++) expect_pop($sformatf("drain2_%0d", k), 8'(k), 1'b0, 1'b0);
    chk("drained2_empty", {31'd0, ev_valid}, 32'd0);

    // empty + push with rd_en: push only
    @(negedge clk);
    rx_data = 8'h2A; rx_done_tick = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; rd_en = 1'b0;
    expect_pop("empty_pushpop", 8'h2A, 1'b0, 1'b0);

    // ---- back-to-back bytes: E0 F0 75 21 22 with no gaps ----
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data = 8'hE0; @(negedge clk);
    rx_data = 8'hF0; @(negedge clk);
    rx_data = 8'h75; @(negedge clk);
    rx_data = 8'h21; @(negedge clk);
    rx_data = 8'h22; @(negedge clk);
    rx_done_tick = 1'b0;
    expect_pop("b2b_0", 8'h75, 1'b1, 1'b1);
    expect_pop("b2b_1", 8'h21, 1'b0, 1'b0);
    expect_pop("b2b_2", 8'h22, 1'b0, 1'b0);
    chk("b2b_empty", {31'd0, ev_valid}, 32'd0);

    // ---- timeout: short wait keeps prefix, full wait drops it ----
    send_byte(8'hE0);
    repeat (TMO / 2) @(negedge clk);
    send_byte(8'h1C);
    expect_pop("no_timeout_yet", 8'h1C, 1'b1, 1'b0);
    send_byte(8'hE0);
    repeat (TMO) @(negedge clk);
    chk("timeout_no_event", {31'd0, ev_valid}, 32'd0);
    send_byte(8'h1C);
    expect_pop("after_timeout", 8'h1C, 1'b0, 1'b0);

    // ---- reset mid-sequence also clears modifiers ----
    send_byte(8'h12);
    pop_one();
    chk("shift_before_reset", {31'd0, shift}, 32'd1);
    send_byte(8'hF0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid_shift", {31'd0, shift}, 32'd0);
    send_byte(8'h1C);
    expect_pop("after_reset", 8'h1C, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
